load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage front end that sits directly upstream of the word-addressed data memory (`dataMemory`: posedge-sampled `writePin`/`readPin`, registered `readOut`).
- Accepts byte, halfword and word load/store requests from the execute stage.
- Converts byte addresses to word indices.
- Performs read-modify-write for sub-word stores.
- Aligns and sign- or zero-extends load data.
- Returns one response per request.

Parameters:
- MEM_WORDS, 4, number of 32-bit words in the attached data memory; word indices >= MEM_WORDS are out of range.
- BIG_ENDIAN, 0, 0 = byte offset 0 maps to bits [7:0]; 1 = byte offset 0 maps to bits [31:24].

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rstN  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept; high only in IDLE.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- reqSigned  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- reqAddr  in  32  byte address.
- reqData  in  32  store data, right-justified.
- respValid  out  1  one-cycle response pulse.
- respErr  out  1  qualified by respValid: misaligned, illegal size or out of range.
- respData  out  32  load result; 0 for stores and errors.
- memAdr  out  32  word index to memory, = latched reqAddr >> 2.
- memWriteIn  out  32  full word to write.
- memWritePin  out  1  memory write strobe.
- memReadPin  out  1  memory read strobe.
- memReadOut  in  32  memory registered read data.

Behaviour:
- Reset: state = IDLE; respData = 0; latched request registers = 0.
  - reqReady = 1; respValid = 0; respErr = 0; memReadPin = 0; memWritePin = 0; memWriteIn = 0; memAdr = 0.
  - Reset asserted mid-operation aborts immediately. Strobes decode from state, so they drop asynchronously and no write occurs at the next edge.
- Handshake: a request is accepted at a posedge when reqValid && reqReady. The edge latches write, size, signed, addr and data. Inputs are ignored otherwise.
- States: IDLE, RD, MRG, WR, RESP.
- Error check at accept (priority: size == 3, then misalignment, then range):
  - half with addr[0] = 1 is misaligned;
  - word with addr[1:0] != 0 is misaligned;
  - (addr >> 2) >= MEM_WORDS is out of range.
  - An error request goes IDLE -> RESP with respErr = 1 and makes no memory access.
- Word store: IDLE -> WR -> RESP. In WR, memWritePin = 1 and memWriteIn = latched data.
- Sub-word store: IDLE -> RD -> MRG -> WR -> RESP.
  - RD: memReadPin = 1.
  - MRG: the merge register captures memReadOut with the selected lane(s) replaced by data[7:0] or data[15:0].
  - WR: writes the merged word.
- Load: IDLE -> RD -> MRG -> RESP.
  - MRG: respData register captures the lane extracted from memReadOut and extended per reqSigned. Word loads pass through unchanged.
- Lane selection: lane = addr[1:0] (half: addr[1]). With BIG_ENDIAN = 1 the lane is mirrored.
- RESP: respValid = 1 for exactly one cycle, then IDLE. reqReady = 0 during RESP. A new request can be accepted in the following IDLE cycle.
- Latency from accept edge to the respValid cycle:
  - load: 3 cycles;
  - word store: 2 cycles;
  - sub-word store: 4 cycles;
  - error: 1 cycle.
- memAdr holds the latched word index from accept until the next accept. memReadPin is high only in RD; memWritePin is high only in WR; they are never high together.
- respData holds its value until the next load or error response; it is cleared to 0 on store and error responses.

Optional Feature:
- Macro: LSU_ERR_CHECK_EN.
- Defined: error checking as above.
- Undefined: respErr is tied to 0, and the low address bits are ignored (half uses addr[1] only, word ignores addr[1:0]). Size 3 is treated as word. The out-of-range index is truncated to $clog2(MEM_WORDS) bits. All requests access memory.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2;
  - state enum (IDLE, RD, MRG, WR, RESP);
  - lane-mask constants.
- Sub-module lsu_lane_align: combinational lane extract with sign/zero-extend, plus lane merge for stores. Instantiated once; it keeps the FSM file free of byte-steering logic.

Test Plan:
- Preload word 1 = 0x8899AABB. Load byte, signed, addr 0x5 -> respValid in 3rd cycle after accept, respData = 0xFFFFFFAA, respErr = 0.
- Same word, load half, unsigned, addr 0x6 -> respData = 0x00008899. Load word addr 0x4 -> 0x8899AABB.
- Store byte 0x11 to addr 0x6, then load word addr 0x4 -> 0x8811AABB. Observe memReadPin for 1 cycle, then memWritePin for 1 cycle, never overlapping.
- Store word 0xDEADBEEF to addr 0xC; load word addr 0xC -> 0xDEADBEEF. Check word-store latency of 2 cycles and memAdr = 3.
- Load word addr 0x2, store half addr 0x3, size 3, then addr 0x10 with MEM_WORDS = 4 -> each gives respErr = 1 one cycle after accept, with no memReadPin/memWritePin.
- Assert rstN low during the RD cycle of a sub-word store -> strobes drop immediately, memory unchanged, reqReady = 1 after release, and the next load returns the original word.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: size encodings, FSM states, lane masks.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP} lsuState_e;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

  function automatic logic isSubWord(input logic [1:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
interface load_store_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqAddr;
  logic [31:0] reqData;
  logic        respValid;
  logic        respErr;
  logic [31:0] respData;
  logic [31:0] memAdr;
  logic [31:0] memWriteIn;
  logic        memWritePin;
  logic        memReadPin;
  logic [31:0] memReadOut;

  // Requester and memory side.
  modport master (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memReadOut,
    input  reqReady, respValid, respErr, respData, memAdr, memWriteIn, memWritePin, memReadPin
  );

  // Load/store unit side.
  modport slave (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memReadOut,
    output reqReady, respValid, respErr, respData, memAdr, memWriteIn, memWritePin, memReadPin
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load lanes, merges sub-word store data into a word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [1:0]  offset,
  input  logic [31:0] memWord,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic [31:0] mergeData
);

  logic [4:0]  shamt;
  logic [31:0] laneMask;
  logic [31:0] lane;

  always_comb begin
    shamt    = '0;
    laneMask = WORD_MASK;
    case (size)
      SZ_BYTE: begin
        shamt    = {(BIG_ENDIAN ? ~offset : offset), 3'b000};
        laneMask = BYTE_MASK;
      end
      SZ_HALF: begin
        shamt    = {(BIG_ENDIAN ? ~offset[1] : offset[1]), 4'b0000};
        laneMask = HALF_MASK;
      end
      default: ;
    endcase
  end

  assign lane = memWord >> shamt;

  always_comb begin
    loadData = memWord;
    case (size)
      SZ_BYTE: loadData = {{24{signExt & lane[7]}}, lane[7:0]};
      SZ_HALF: loadData = {{16{signExt & lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  assign mergeData = (memWord & ~(laneMask << shamt)) | ((storeData & laneMask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end with sub-word read-modify-write.
// LSU_ERR_CHECK_EN enables misalignment / illegal-size / range errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 4,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input logic              clk,
  input logic              rstN,
  load_store_unit_if.slave bus
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  lsuState_e   stateQ, stateD;
  logic        writeQ, signedQ, errQ;
  logic [1:0]  sizeQ;
  logic [31:0] addrQ, dataQ, mergeQ, respDataQ;
  logic [31:0] mergeD, respDataD;
  logic [31:0] loadWord, mergeWord;
  logic        accept, reqErr, wordStore;

  assign accept    = bus.reqValid && (stateQ == IDLE);
  assign wordStore = bus.reqWrite && !isSubWord(bus.reqSize);

`ifdef LSU_ERR_CHECK_EN
  always_comb begin
    reqErr = 1'b0;
    if (bus.reqSize == SZ_ILL)                            reqErr = 1'b1;
    else if (bus.reqSize == SZ_HALF && bus.reqAddr[0])    reqErr = 1'b1;
    else if (bus.reqSize == SZ_WORD && |bus.reqAddr[1:0]) reqErr = 1'b1;
    else if ((bus.reqAddr >> 2) >= 32'(MEM_WORDS))        reqErr = 1'b1;
  end

  assign bus.memAdr = addrQ >> 2;
`else
  logic unusedAddr;

  assign reqErr     = 1'b0;
  // Out-of-range indices wrap onto the attached memory.
  assign bus.memAdr = {{(30 - IdxW){1'b0}}, addrQ[IdxW+1:2]};
  assign unusedAddr = ^addrQ[31:IdxW+2];
`endif

  lsu_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) uAlign (
    .size     (sizeQ),
    .signExt  (signedQ),
    .offset   (addrQ[1:0]),
    .memWord  (bus.memReadOut),
    .storeData(dataQ),
    .loadData (loadWord),
    .mergeData(mergeWord)
  );

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: if (accept) stateD = reqErr ? RESP : (wordStore ? WR : RD);
      RD:   stateD = MRG;
      MRG:  stateD = writeQ ? WR : RESP;
      WR:   stateD = RESP;
      RESP: stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    mergeD    = mergeQ;
    respDataD = respDataQ;
    if (stateQ == MRG) begin
      if (writeQ) mergeD    = mergeWord;
      else        respDataD = loadWord;
    end
    // Store and error responses report zero data.
    if ((stateQ == WR) || (accept && reqErr)) respDataD = '0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ    <= IDLE;
      writeQ    <= 1'b0;
      sizeQ     <= '0;
      signedQ   <= 1'b0;
      errQ      <= 1'b0;
      addrQ     <= '0;
      dataQ     <= '0;
      mergeQ    <= '0;
      respDataQ <= '0;
    end else begin
      stateQ    <= stateD;
      mergeQ    <= mergeD;
      respDataQ <= respDataD;
      if (accept) begin
        writeQ  <= bus.reqWrite;
        sizeQ   <= bus.reqSize;
        signedQ <= bus.reqSigned;
        errQ    <= reqErr;
        addrQ   <= bus.reqAddr;
        dataQ   <= bus.reqData;
      end
    end
  end

  // Strobes decode from state so an asynchronous reset drops them at once.
  assign bus.reqReady    = (stateQ == IDLE);
  assign bus.respValid   = (stateQ == RESP);
  assign bus.respErr     = (stateQ == RESP) && errQ;
  assign bus.respData    = respDataQ;
  assign bus.memReadPin  = (stateQ == RD);
  assign bus.memWritePin = (stateQ == WR);
  assign bus.memWriteIn  = (stateQ == WR) ? (isSubWord(sizeQ) ? mergeQ : dataQ) : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read data memory model.
// Error cases are exercised when LSU_ERR_CHECK_EN is defined.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk;
  logic rstN;
  logic memInit;
  logic [31:0] mem [4];
  logic [31:0] memReadOutQ;

  int checks;
  int errors;

  int          lat, nRd, nWr, firstRd, firstWr;
  logic        overlap, rErr;
  logic [31:0] rData, adrSeen;

  load_store_unit_if bus ();

  load_store_unit #(
    .MEM_WORDS (4),
    .BIG_ENDIAN(1'b0)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memInit) begin
      mem[0] <= 32'h0;
      mem[1] <= 32'h8899AABB;
      mem[2] <= 32'h0;
      mem[3] <= 32'h0;
    end else begin
      if (bus.memWritePin) mem[bus.memAdr[1:0]] <= bus.memWriteIn;
      if (bus.memReadPin)  memReadOutQ <= mem[bus.memAdr[1:0]];
    end
  end
  assign bus.memReadOut = memReadOutQ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and observes up to 12 cycles after the accept edge.
  task automatic runReq(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    chk("ready_before_req", 32'(bus.reqReady), 32'd1);
    bus.reqValid  = 1'b1;
    bus.reqWrite  = w;
    bus.reqSize   = sz;
    bus.reqSigned = sg;
    bus.reqAddr   = a;
    bus.reqData   = d;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    bus.reqAddr  = 32'hFFFF_FFFF;
    bus.reqData  = 32'h0;
    lat = 0; nRd = 0; nWr = 0; firstRd = 0; firstWr = 0;
    overlap = 1'b0; rErr = 1'bx; rData = 32'hx; adrSeen = 32'hx;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) adrSeen = bus.memAdr;
      if (bus.memReadPin) begin
        nRd++;
        if (firstRd == 0) firstRd = k;
      end
      if (bus.memWritePin) begin
        nWr++;
        if (firstWr == 0) firstWr = k;
      end
      if (bus.memReadPin && bus.memWritePin) overlap = 1'b1;
      if (bus.respValid) begin
        lat   = k;
        rData = bus.respData;
        rErr  = bus.respErr;
        break;
      end
    end
  endtask

  task automatic checkResp(input string tag, input int expLat, input logic [31:0] expData,
                           input logic expErr, input int expRd, input int expWr);
    chk({tag, "_latency"}, 32'(lat), 32'(expLat));
    chk({tag, "_data"}, rData, expData);
    chk({tag, "_err"}, 32'(rErr), 32'(expErr));
    chk({tag, "_reads"}, 32'(nRd), 32'(expRd));
    chk({tag, "_writes"}, 32'(nWr), 32'(expWr));
    chk({tag, "_overlap"}, 32'(overlap), 32'd0);
    @(negedge clk);
    chk({tag, "_resp_one_cycle"}, 32'(bus.respValid), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstN          = 1'b0;
    memInit       = 1'b1;
    bus.reqValid  = 1'b0;
    bus.reqWrite  = 1'b0;
    bus.reqSize   = SZ_BYTE;
    bus.reqSigned = 1'b0;
    bus.reqAddr   = '0;
    bus.reqData   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    memInit = 1'b0;
    chk("rst_reqReady", 32'(bus.reqReady), 32'd1);
    chk("rst_respValid", 32'(bus.respValid), 32'd0);
    chk("rst_respErr", 32'(bus.respErr), 32'd0);
    chk("rst_memReadPin", 32'(bus.memReadPin), 32'd0);
    chk("rst_memWritePin", 32'(bus.memWritePin), 32'd0);
    chk("rst_memWriteIn", bus.memWriteIn, 32'h0);
    chk("rst_memAdr", bus.memAdr, 32'h0);
    chk("rst_respData", bus.respData, 32'h0);
    rstN = 1'b1;

    runReq(1'b0, SZ_BYTE, 1'b1, 32'h5, 32'h0);
    checkResp("ldb_signed_5", 3, 32'hFFFFFFAA, 1'b0, 1, 0);
    runReq(1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0);
    checkResp("ldh_unsigned_6", 3, 32'h00008899, 1'b0, 1, 0);
    runReq(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    checkResp("ldw_4", 3, 32'h8899AABB, 1'b0, 1, 0);

    runReq(1'b1, SZ_BYTE, 1'b0, 32'h6, 32'hFFFF_FF11);
    checkResp("stb_6", 4, 32'h0, 1'b0, 1, 1);
    chk("stb_6_read_cycle", 32'(firstRd), 32'd1);
    chk("stb_6_write_cycle", 32'(firstWr), 32'd3);
    runReq(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    checkResp("ldw_4_after_stb", 3, 32'h8811AABB, 1'b0, 1, 0);

    runReq(1'b1, SZ_WORD, 1'b0, 32'hC, 32'hDEADBEEF);
    checkResp("stw_c", 2, 32'h0, 1'b0, 0, 1);
    chk("stw_c_memAdr", adrSeen, 32'd3);
    runReq(1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0);
    checkResp("ldw_c", 3, 32'hDEADBEEF, 1'b0, 1, 0);

`ifdef LSU_ERR_CHECK_EN
    runReq(1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0);
    checkResp("err_ldw_misaligned", 1, 32'h0, 1'b1, 0, 0);
    runReq(1'b1, SZ_HALF, 1'b0, 32'h3, 32'h1234);
    checkResp("err_sth_misaligned", 1, 32'h0, 1'b1, 0, 0);
    runReq(1'b0, SZ_ILL, 1'b0, 32'h0, 32'h0);
    checkResp("err_size3", 1, 32'h0, 1'b1, 0, 0);
    runReq(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    checkResp("err_range", 1, 32'h0, 1'b1, 0, 0);
`else
    runReq(1'b0, SZ_WORD, 1'b0, 32'hE, 32'h0);
    checkResp("nochk_ldw_low_bits_ignored", 3, 32'hDEADBEEF, 1'b0, 1, 0);
    runReq(1'b0, SZ_ILL, 1'b0, 32'h5, 32'h0);
    checkResp("nochk_size3_as_word", 3, 32'h8811AABB, 1'b0, 1, 0);
    runReq(1'b0, SZ_BYTE, 1'b0, 32'h15, 32'h0);
    checkResp("nochk_range_wraps", 3, 32'h000000AA, 1'b0, 1, 0);
`endif

    // Reset during the RD cycle of a sub-word store.
    @(negedge clk);
    bus.reqValid  = 1'b1;
    bus.reqWrite  = 1'b1;
    bus.reqSize   = SZ_BYTE;
    bus.reqSigned = 1'b0;
    bus.reqAddr   = 32'h4;
    bus.reqData   = 32'h55;
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    @(negedge clk);
    chk("abort_rd_active", 32'(bus.memReadPin), 32'd1);
    rstN = 1'b0;
    #1;
    chk("abort_readPin_drop", 32'(bus.memReadPin), 32'd0);
    chk("abort_writePin_low", 32'(bus.memWritePin), 32'd0);
    chk("abort_ready", 32'(bus.reqReady), 32'd1);
    chk("abort_memAdr", bus.memAdr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    chk("abort_ready_after_release", 32'(bus.reqReady), 32'd1);
    runReq(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    checkResp("abort_ldw_4", 3, 32'h8811AABB, 1'b0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
